// File: rtl/alu_operand_sequencer.sv
// ----------------------------------------------------------------------------
// alu_operand_sequencer
//
// Sequential front end and result latch for the N-bit ALU. A single shared
// switch bus (data_in) and one load button are used to enter operand A,
// operand B and the 2-bit opcode in turn. The captured values drive the ALU
// directly; one cycle after the opcode is entered the ALU's combinational
// Result and {n,c,z,v} Status are latched and held for display until the
// next load press starts a new operation.
//
// Ports:
//   clk          in   rising-edge system clock
//   rst_n        in   asynchronous active-low reset
//   data_in      in   N-bit switch bus; [1:0] carry the opcode in GET_OP
//   load         in   debounced, synchronized button level (rising edge acts)
//   clear        in   synchronous abort to GET_A, overrides load
//   alu_a        out  registered operand A to the ALU
//   alu_b        out  registered operand B to the ALU
//   alu_opcode   out  registered opcode to the ALU
//   alu_result   in   combinational ALU Result
//   alu_status   in   combinational ALU Status {n,c,z,v}
//   result_q     out  latched ALU Result
//   status_q     out  latched ALU Status {n,c,z,v}
//   result_valid out  high while result_q/status_q hold a completed operation
//   step         out  2-bit state code for the LEDs
//   display      out  data_in while entering values, result_q in SHOW
// ----------------------------------------------------------------------------
module alu_operand_sequencer #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] data_in,
  input  logic         load,
  input  logic         clear,
  output logic [N-1:0] alu_a,
  output logic [N-1:0] alu_b,
  output logic [1:0]   alu_opcode,
  input  logic [N-1:0] alu_result,
  input  logic [3:0]   alu_status,
  output logic [N-1:0] result_q,
  output logic [3:0]   status_q,
  output logic         result_valid,
  output logic [1:0]   step,
  output logic [N-1:0] display
);

  // EXEC and SHOW both show step 11 on the LEDs, so bit 2 of the state
  // register is what tells them apart; step is simply state_q[1:0].
  localparam logic [2:0] ST_GET_A  = 3'b000;
  localparam logic [2:0] ST_GET_B  = 3'b001;
  localparam logic [2:0] ST_GET_OP = 3'b010;
  localparam logic [2:0] ST_EXEC   = 3'b011;
  localparam logic [2:0] ST_SHOW   = 3'b111;

  logic [2:0]   state_q,        state_d;
  logic         load_prev_q,    load_prev_d;
  logic [N-1:0] alu_a_q,        alu_a_d;
  logic [N-1:0] alu_b_q,        alu_b_d;
  logic [1:0]   alu_opcode_q,   alu_opcode_d;
  logic [N-1:0] result_d;
  logic [3:0]   status_d;
  logic         result_valid_q, result_valid_d;
  logic         ld_edge;

  // A press is the rising edge of the already-debounced load level. Because
  // load_prev resets to 1, a button held through reset looks like "already
  // seen" and cannot advance the sequence until it is released and pressed.
  assign ld_edge = load & ~load_prev_q;

  // Next-state and datapath capture logic. clear is checked first so that a
  // simultaneous press is discarded; load_prev still tracks load in every
  // case, which means that discarded press is consumed rather than deferred.
  always_comb begin
    state_d        = state_q;
    load_prev_d    = load;
    alu_a_d        = alu_a_q;
    alu_b_d        = alu_b_q;
    alu_opcode_d   = alu_opcode_q;
    result_d       = result_q;
    status_d       = status_q;
    result_valid_d = result_valid_q;

    if (clear) begin
      state_d        = ST_GET_A;
      alu_a_d        = '0;
      alu_b_d        = '0;
      alu_opcode_d   = '0;
      result_d       = '0;
      status_d       = '0;
      result_valid_d = 1'b0;
    end else begin
      case (state_q)
        ST_GET_A: begin
          if (ld_edge) begin
            alu_a_d = data_in;
            state_d = ST_GET_B;
          end
        end
        ST_GET_B: begin
          if (ld_edge) begin
            alu_b_d = data_in;
            state_d = ST_GET_OP;
          end
        end
        ST_GET_OP: begin
          if (ld_edge) begin
            alu_opcode_d = data_in[1:0];
            state_d      = ST_EXEC;
          end
        end
        // The ALU has had a full cycle to settle on the new operands and
        // opcode; any press arriving now is deliberately dropped.
        ST_EXEC: begin
          result_d       = alu_result;
          status_d       = alu_status;
          result_valid_d = 1'b1;
          state_d        = ST_SHOW;
        end
        // Operands are kept on return to GET_A so the ALU inputs do not
        // glitch; only the valid flag is withdrawn.
        ST_SHOW: begin
          if (ld_edge) begin
            result_valid_d = 1'b0;
            state_d        = ST_GET_A;
          end
        end
        default: begin
          state_d = ST_GET_A;
        end
      endcase
    end
  end

  // State and data registers. Reset puts every data register to zero and
  // treats load as already high, so nothing is captured out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= ST_GET_A;
      load_prev_q    <= 1'b1;
      alu_a_q        <= '0;
      alu_b_q        <= '0;
      alu_opcode_q   <= '0;
      result_q       <= '0;
      status_q       <= '0;
      result_valid_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      load_prev_q    <= load_prev_d;
      alu_a_q        <= alu_a_d;
      alu_b_q        <= alu_b_d;
      alu_opcode_q   <= alu_opcode_d;
      result_q       <= result_d;
      status_q       <= status_d;
      result_valid_q <= result_valid_d;
    end
  end

  assign alu_a        = alu_a_q;
  assign alu_b        = alu_b_q;
  assign alu_opcode   = alu_opcode_q;
  assign result_valid = result_valid_q;
  assign step         = state_q[1:0];

  // During EXEC result_q is still stale, so the switches stay on display
  // until the latched result is actually present.
  assign display = (state_q == ST_SHOW) ? result_q : data_in;

endmodule

// File: tb/tb_alu_operand_sequencer.sv
// ----------------------------------------------------------------------------
// tb_alu_operand_sequencer
//
// Directed bench for alu_operand_sequencer with a small behavioural 8-bit
// ALU attached (00 add, 01 subtract, 10 and, 11 or; status {n,c,z,v}).
// Expected values are hand-computed constants.
// ----------------------------------------------------------------------------
module tb_alu_operand_sequencer;

  localparam int N = 8;

  logic         clk;
  logic         rst_n;
  logic [N-1:0] data_in;
  logic         load;
  logic         clear;
  logic [N-1:0] alu_a;
  logic [N-1:0] alu_b;
  logic [1:0]   alu_opcode;
  logic [N-1:0] alu_result;
  logic [3:0]   alu_status;
  logic [N-1:0] result_q;
  logic [3:0]   status_q;
  logic         result_valid;
  logic [1:0]   step;
  logic [N-1:0] display;

  int checks;
  int errors;

  alu_operand_sequencer #(.N(N)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .data_in      (data_in),
    .load         (load),
    .clear        (clear),
    .alu_a        (alu_a),
    .alu_b        (alu_b),
    .alu_opcode   (alu_opcode),
    .alu_result   (alu_result),
    .alu_status   (alu_status),
    .result_q     (result_q),
    .status_q     (status_q),
    .result_valid (result_valid),
    .step         (step),
    .display      (display)
  );

  // Behavioural ALU standing in for the real one on the board.
  always_comb begin
    logic [N:0] wide;
    logic       v;
    wide = '0;
    v    = 1'b0;
    case (alu_opcode)
      2'b00: begin
        wide = {1'b0, alu_a} + {1'b0, alu_b};
        v    = (alu_a[N-1] == alu_b[N-1]) && (wide[N-1] != alu_a[N-1]);
      end
      2'b01: begin
        wide = {1'b0, alu_a} - {1'b0, alu_b};
        v    = (alu_a[N-1] != alu_b[N-1]) && (wide[N-1] != alu_a[N-1]);
      end
      2'b10: wide = {1'b0, alu_a & alu_b};
      default: wide = {1'b0, alu_a | alu_b};
    endcase
    alu_result = wide[N-1:0];
    alu_status = {wide[N-1], wide[N], (wide[N-1:0] == '0), v};
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One press: load rises at a negedge, the next posedge captures, and load
  // falls again at the following negedge where outputs are then stable.
  task automatic press(input logic [N-1:0] value);
    @(negedge clk);
    data_in = value;
    load    = 1'b1;
    @(negedge clk);
    load    = 1'b0;
  endtask

  task automatic test_reset();
    rst_n   = 1'b0;
    load    = 1'b0;
    clear   = 1'b0;
    data_in = 8'h5A;
    #13;
    checks++;
    if (step !== 2'b00) begin
      errors++;
      $display("[TB] FAIL reset_step got %b want 00", step);
    end
    checks++;
    if ({alu_a, alu_b, alu_opcode, result_q, status_q, result_valid} !== '0) begin
      errors++;
      $display("[TB] FAIL reset_regs got a=%h b=%h op=%b r=%h s=%b v=%b want all 0",
               alu_a, alu_b, alu_opcode, result_q, status_q, result_valid);
    end
    checks++;
    if (display !== 8'h5A) begin
      errors++;
      $display("[TB] FAIL reset_display got %h want 5a", display);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_add_basic();
    press(8'h05);
    checks++;
    if (alu_a !== 8'h05 || step !== 2'b01) begin
      errors++;
      $display("[TB] FAIL add_capture_a got a=%h step=%b want 05 01", alu_a, step);
    end
    press(8'h03);
    checks++;
    if (alu_b !== 8'h03 || step !== 2'b10) begin
      errors++;
      $display("[TB] FAIL add_capture_b got b=%h step=%b want 03 10", alu_b, step);
    end
    press(8'hFC);
    data_in = 8'hEE;
    checks++;
    if (alu_opcode !== 2'b00 || step !== 2'b11 || result_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL add_exec got op=%b step=%b valid=%b want 00 11 0",
               alu_opcode, step, result_valid);
    end
    @(negedge clk);
    checks++;
    if (result_q !== 8'h08 || status_q !== 4'b0000 || result_valid !== 1'b1) begin
      errors++;
      $display("[TB] FAIL add_result got r=%h s=%b valid=%b want 08 0000 1",
               result_q, status_q, result_valid);
    end
    checks++;
    if (display !== 8'h08 || step !== 2'b11) begin
      errors++;
      $display("[TB] FAIL add_show got display=%h step=%b want 08 11", display, step);
    end
  endtask

  task automatic test_show_return();
    press(8'h11);
    checks++;
    if (result_valid !== 1'b0 || step !== 2'b00) begin
      errors++;
      $display("[TB] FAIL show_return got valid=%b step=%b want 0 00", result_valid, step);
    end
    checks++;
    if (alu_a !== 8'h05 || alu_b !== 8'h03 || display !== 8'h11) begin
      errors++;
      $display("[TB] FAIL show_keep got a=%h b=%h display=%h want 05 03 11",
               alu_a, alu_b, display);
    end
  endtask

  task automatic test_overflow();
    press(8'h7F);
    press(8'h01);
    press(8'h00);
    @(negedge clk);
    checks++;
    if (result_q !== 8'h80 || status_q !== 4'b1001 || result_valid !== 1'b1) begin
      errors++;
      $display("[TB] FAIL overflow got r=%h s=%b valid=%b want 80 1001 1",
               result_q, status_q, result_valid);
    end
    press(8'h00);
  endtask

  task automatic test_load_held();
    @(negedge clk);
    data_in = 8'h22;
    load    = 1'b1;
    repeat (10) @(negedge clk);
    checks++;
    if (step !== 2'b01 || alu_a !== 8'h22) begin
      errors++;
      $display("[TB] FAIL held_once got step=%b a=%h want 01 22", step, alu_a);
    end
    load = 1'b0;
    @(negedge clk);
    press(8'h33);
    checks++;
    if (step !== 2'b10 || alu_b !== 8'h33) begin
      errors++;
      $display("[TB] FAIL held_second got step=%b b=%h want 10 33", step, alu_b);
    end
  endtask

  task automatic test_clear_with_edge();
    @(negedge clk);
    data_in = 8'h02;
    clear   = 1'b1;
    load    = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    checks++;
    if (step !== 2'b00 ||
        {alu_a, alu_b, alu_opcode, result_q, status_q, result_valid} !== '0) begin
      errors++;
      $display("[TB] FAIL clear_regs got step=%b a=%h b=%h op=%b r=%h s=%b v=%b want 00 all 0",
               step, alu_a, alu_b, alu_opcode, result_q, status_q, result_valid);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (step !== 2'b00 || alu_a !== 8'h00) begin
      errors++;
      $display("[TB] FAIL clear_consumed got step=%b a=%h want 00 00", step, alu_a);
    end
    load = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset_load_high();
    @(negedge clk);
    rst_n   = 1'b0;
    load    = 1'b1;
    data_in = 8'h44;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (step !== 2'b00 || alu_a !== 8'h00) begin
      errors++;
      $display("[TB] FAIL reset_held got step=%b a=%h want 00 00", step, alu_a);
    end
    load = 1'b0;
    @(negedge clk);
    press(8'h44);
    checks++;
    if (step !== 2'b01 || alu_a !== 8'h44) begin
      errors++;
      $display("[TB] FAIL reset_held_press got step=%b a=%h want 01 44", step, alu_a);
    end
  endtask

  task automatic test_async_reset();
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (step !== 2'b00 || alu_a !== 8'h00 || result_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL async_reset got step=%b a=%h valid=%b want 00 00 0",
               step, alu_a, result_valid);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    checks  = 0;
    errors  = 0;
    rst_n   = 1'b0;
    load    = 1'b0;
    clear   = 1'b0;
    data_in = '0;
    test_reset();
    test_add_basic();
    test_show_return();
    test_overflow();
    test_load_held();
    test_clear_with_edge();
    test_reset_load_high();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
